// File: rtl/nn_layer_sequencer.sv
// Layer sequencer for the 3-3-6-4-1 MLP: accepts an input vector, steps the ALU
// through every layer with ReLU + rescale in between, and returns the final neuron.
module nn_layer_sequencer #(
    parameter int NUM_LAYERS    = 4,
    parameter int ELEM_W        = 64,
    parameter int MAX_ELEMS     = 6,
    parameter int FRAC_SHIFT    = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3*ELEM_W-1:0]           in_data,
    output logic [1:0]                    layer_number,
    input  logic [3:0]                    cols,
    output logic                          alu_enable,
    output logic [MAX_ELEMS*ELEM_W-1:0]   alu_operand,
    input  logic [MAX_ELEMS*ELEM_W-1:0]   alu_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ELEM_W-1:0]             out_data,
    output logic                          out_class,
    output logic                          busy
);

    localparam int         OP_W        = MAX_ELEMS * ELEM_W;
    localparam logic [1:0] LAST_LAYER  = 2'(NUM_LAYERS - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COMPUTE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [3:0]        r_settle;
    logic [1:0]        r_layer;
    logic [OP_W-1:0]   r_operand;
    logic              r_out_valid;
    logic              r_out_class;
    logic [ELEM_W-1:0] r_out_data;

    logic [OP_W-1:0]   w_in_ext;
    logic [OP_W-1:0]   w_repacked;

    assign w_in_ext = {{(OP_W - 3*ELEM_W){1'b0}}, in_data};

    // Result slot j and next-layer operand slot j share bit positions, so the
    // repack is slot-local: ReLU, rescale, and clear slots beyond cols.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_ELEMS; gi++) begin : g_relu
            localparam logic [3:0] SLOT = 4'(gi);
            logic signed [ELEM_W-1:0] w_elem;
            assign w_elem = alu_result[gi*ELEM_W +: ELEM_W];
            assign w_repacked[gi*ELEM_W +: ELEM_W] =
                (SLOT < cols && !w_elem[ELEM_W-1]) ? ELEM_W'(w_elem >>> FRAC_SHIFT) : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_layer     <= '0;
            r_operand   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_class <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_operand <= w_in_ext;
                        r_layer   <= '0;
                        r_settle  <= SETTLE_INIT;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == 4'd0) begin
                        r_state <= S_COMPUTE;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                S_COMPUTE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (r_layer == LAST_LAYER) begin
                        r_out_data  <= alu_result[ELEM_W-1:0];
                        r_out_class <= !alu_result[ELEM_W-1] && (alu_result[ELEM_W-1:0] != '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_operand <= w_repacked;
                        r_layer   <= r_layer + 2'd1;
                        r_settle  <= SETTLE_INIT;
                        r_state   <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign alu_enable   = (r_state == S_COMPUTE);
    assign layer_number = r_layer;
    assign alu_operand  = r_operand;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_class    = r_out_class;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: two instances (settle 1 and 3) each driving a
// stub ALU with random weights, checked against a whole-network reference model.
module tb_nn_layer_sequencer;

    localparam int EW = 64;
    localparam int ME = 6;
    localparam int BW = EW * ME;
    localparam int ROWS_TBL [4] = '{3, 3, 6, 4};
    localparam int COLS_TBL [4] = '{3, 6, 4, 1};
    localparam int SETTLE_TBL [2] = '{1, 3};

    logic          clk;
    logic          rst_n;
    logic          in_valid     [2];
    logic          in_ready     [2];
    logic [3*EW-1:0] in_data    [2];
    logic [1:0]    layer_number [2];
    logic [3:0]    cols_r       [2];
    logic          alu_enable   [2];
    logic [BW-1:0] alu_operand  [2];
    logic [BW-1:0] alu_result   [2];
    logic          out_valid    [2];
    logic          out_ready    [2];
    logic [EW-1:0] out_data     [2];
    logic          out_class    [2];
    logic          busy         [2];

    longint W [4][6][6];
    longint B [4][6];
    bit     force_l0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int overlap = 0;
    int acc_cyc [2];
    int en_n [2];
    int en_lat [2][8];
    int en_layer [2][8];

    typedef struct {
        longint x [3];
        longint exp_data;
        bit     exp_class;
    } vec_t;
    vec_t tbl [8];

    nn_layer_sequencer #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .layer_number(layer_number[0]), .cols(cols_r[0]),
        .alu_enable(alu_enable[0]), .alu_operand(alu_operand[0]), .alu_result(alu_result[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_class(out_class[0]), .busy(busy[0])
    );

    nn_layer_sequencer #(.SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .layer_number(layer_number[1]), .cols(cols_r[1]),
        .alu_enable(alu_enable[1]), .alu_operand(alu_operand[1]), .alu_result(alu_result[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_class(out_class[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub ALU: unpacks the operand by element index, y = W*x + b, registered on enable.
    function automatic logic [BW-1:0] alu_model(input logic [BW-1:0] op, input logic [1:0] l);
        logic [BW-1:0] r;
        longint x [6];
        longint y;
        int rows;
        int c;
        r = '0;
        rows = ROWS_TBL[l];
        c = COLS_TBL[l];
        if (force_l0 && l == 2'd0) begin
            r[191:128] = 64'hFFFF_FFFF_FFFF_FFFB;
            r[127:64]  = 64'd256;
            r[63:0]    = 64'd1000;
            return r;
        end
        for (int i = 0; i < rows; i++) x[i] = longint'(op[EW*(rows-1-i) +: EW]);
        for (int j = 0; j < c; j++) begin
            y = B[l][j];
            for (int i = 0; i < rows; i++) y += W[l][j][i] * x[i];
            r[EW*(c-1-j) +: EW] = y;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cols_r[k] <= 4'(COLS_TBL[layer_number[k]]);
            if (alu_enable[k]) alu_result[k] <= alu_model(alu_operand[k], layer_number[k]);
        end
    end

    // Whole-network reference: plain arrays, ReLU and >>>8 between layers.
    function automatic longint ref_infer(input longint x0, input longint x1, input longint x2);
        longint v [6];
        longint y [6];
        int n;
        v = '{default: 0};
        y = '{default: 0};
        v[0] = x0; v[1] = x1; v[2] = x2;
        n = 3;
        for (int l = 0; l < 4; l++) begin
            for (int j = 0; j < COLS_TBL[l]; j++) begin
                y[j] = B[l][j];
                for (int i = 0; i < n; i++) y[j] += W[l][j][i] * v[i];
            end
            if (l == 3) return y[0];
            for (int j = 0; j < COLS_TBL[l]; j++) v[j] = (y[j] < 0) ? 0 : (y[j] >>> 8);
            n = COLS_TBL[l];
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (in_valid[k] && in_ready[k]) begin
                acc_cyc[k] = cyc;
                en_n[k] = 0;
            end
            if (alu_enable[k] && en_n[k] < 8) begin
                en_lat[k][en_n[k]] = cyc - acc_cyc[k];
                en_layer[k][en_n[k]] = int'(layer_number[k]);
                en_n[k]++;
            end
            if (in_ready[k] && out_valid[k]) overlap++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, $signed(act), act, $signed(exp), exp);
        end else begin
            $display("ok   %s = %0d", nm, $signed(act));
        end
    endtask

    task automatic chk_wide(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s", nm);
        end
    endtask

    task automatic start(input int k, input longint x0, input longint x1, input longint x2);
        bit seen;
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (in_ready[k]) begin seen = 1; break; end
        end
        chk("start_in_ready", 64'(seen), 64'd1);
        in_data[k] = {64'(x0), 64'(x1), 64'(x2)};
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input bit do_data, input longint ed, input bit ec, input string nm);
        bit seen;
        int bad_busy;
        int bad_en;
        int s;
        s = SETTLE_TBL[k];
        seen = 0;
        bad_busy = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (out_valid[k]) begin seen = 1; break; end
            if (!busy[k] || in_ready[k]) bad_busy++;
        end
        chk({nm, "_out_valid"}, 64'(seen), 64'd1);
        chk({nm, "_latency"}, 64'(cyc - acc_cyc[k]), 64'(4*(s+2)+1));
        bad_en = (en_n[k] == 4) ? 0 : 1;
        for (int l = 0; l < 4; l++)
            if (en_lat[k][l] != l*(s+2)+s+1 || en_layer[k][l] != l) bad_en++;
        chk({nm, "_enable_timing"}, 64'(bad_en), 64'd0);
        chk({nm, "_busy"}, 64'(bad_busy), 64'd0);
        if (do_data) begin
            chk({nm, "_out_data"}, out_data[k], 64'(ed));
            chk({nm, "_out_class"}, 64'(out_class[k]), 64'(ec));
        end
    endtask

    task automatic release_out(input int k, input string nm);
        @(posedge clk); #1 out_ready[k] = 1'b1;
        @(posedge clk); #1 out_ready[k] = 1'b0;
        chk({nm, "_valid_drop"}, 64'(out_valid[k]), 64'd0);
        chk({nm, "_ready_back"}, 64'(in_ready[k]), 64'd1);
    endtask

    initial begin : main
        logic [BW-1:0] exp_op;
        logic [EW-1:0] held;
        int bad;
        bit seen;

        force_l0 = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 0; out_ready[k] = 0; in_data[k] = '0;
            acc_cyc[k] = 0; en_n[k] = 0;
        end
        for (int l = 0; l < 4; l++)
            for (int j = 0; j < 6; j++) begin
                B[l][j] = 0;
                for (int i = 0; i < 6; i++) W[l][j][i] = longint'($urandom_range(0, 800)) - 400;
            end
        B[3][0] = -82;

        tbl[0].x = '{0, 0, 0};        tbl[0].exp_data = -82; tbl[0].exp_class = 0;
        tbl[1].x = '{1000, -2000, 3000};
        for (int v = 2; v < 8; v++)
            for (int i = 0; i < 3; i++) tbl[v].x[i] = longint'($urandom_range(0, 10000)) - 5000;
        for (int v = 1; v < 8; v++) begin
            tbl[v].exp_data = ref_infer(tbl[v].x[0], tbl[v].x[1], tbl[v].x[2]);
            tbl[v].exp_class = (tbl[v].exp_data > 0);
        end

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst_layer", 64'(layer_number[0]), 64'd0);
        chk_wide("rst_operand", alu_operand[0], '0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            start(0, tbl[v].x[0], tbl[v].x[1], tbl[v].x[2]);
            wait_out(0, 1, tbl[v].exp_data, tbl[v].exp_class, $sformatf("vec%0d", v));
            release_out(0, $sformatf("vec%0d", v));
        end

        // ReLU + rescale of a forced layer-0 result
        force_l0 = 1;
        start(0, 7, 8, 9);
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (layer_number[0] == 2'd1) begin seen = 1; break; end
        end
        exp_op = '0;
        exp_op[63:0] = 64'd3;
        exp_op[127:64] = 64'd1;
        chk("relu_reach_l1", 64'(seen), 64'd1);
        chk_wide("relu_operand_l1", alu_operand[0], exp_op);
        wait_out(0, 0, 0, 0, "relu_run");
        release_out(0, "relu_run");
        force_l0 = 0;

        // Output backpressure
        start(0, tbl[2].x[0], tbl[2].x[1], tbl[2].x[2]);
        wait_out(0, 1, tbl[2].exp_data, tbl[2].exp_class, "bp");
        held = out_data[0];
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (out_data[0] !== held || in_ready[0] || !out_valid[0]) bad++;
        end
        chk("bp_hold", 64'(bad), 64'd0);
        chk("bp_data", out_data[0], 64'(tbl[2].exp_data));
        release_out(0, "bp");

        // Input while busy is ignored
        start(0, tbl[3].x[0], tbl[3].x[1], tbl[3].x[2]);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (layer_number[0] == 2'd1) break;
        end
        in_data[0] = {64'(tbl[4].x[0]), 64'(tbl[4].x[1]), 64'(tbl[4].x[2])};
        in_valid[0] = 1'b1;
        @(posedge clk); #1 in_valid[0] = 1'b0;
        wait_out(0, 1, tbl[3].exp_data, tbl[3].exp_class, "busy_first");
        release_out(0, "busy_first");
        start(0, tbl[4].x[0], tbl[4].x[1], tbl[4].x[2]);
        wait_out(0, 1, tbl[4].exp_data, tbl[4].exp_class, "busy_second");
        release_out(0, "busy_second");

        // Long settle instance
        for (int v = 1; v < 3; v++) begin
            start(1, tbl[v].x[0], tbl[v].x[1], tbl[v].x[2]);
            wait_out(1, 1, tbl[v].exp_data, tbl[v].exp_class, $sformatf("settle3_vec%0d", v));
            release_out(1, $sformatf("settle3_vec%0d", v));
        end

        // Asynchronous reset mid-COMPUTE of layer 2, after a -82 result
        start(0, 0, 0, 0);
        wait_out(0, 1, -82, 0, "pre_rst");
        release_out(0, "pre_rst");
        start(0, tbl[5].x[0], tbl[5].x[1], tbl[5].x[2]);
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (alu_enable[0] && layer_number[0] == 2'd2) begin seen = 1; break; end
        end
        chk("midrst_reach_compute", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("midrst_out_data", out_data[0], 64'd0);
        chk("midrst_alu_enable", 64'(alu_enable[0]), 64'd0);
        chk("midrst_layer", 64'(layer_number[0]), 64'd0);
        chk_wide("midrst_operand", alu_operand[0], '0);
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (out_valid[0] || !in_ready[0] || layer_number[0] != 2'd0) bad++;
        end
        chk("postrst_idle", 64'(bad), 64'd0);

        chk("ready_valid_overlap", 64'(overlap), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Control and inter-layer stage of the 3-3-6-4-1 fixed-point MLP datapath. Accepts one input vector over a valid/ready handshake, then steps `layer_number` through layers 0..3. For each layer it presents the packed operand to the ALU, pulses the ALU enable and captures the ALU result. Between layers it applies ReLU plus an arithmetic rescale, and it returns the final neuron output over a second valid/ready handshake. It replaces the input mux and input register: its `alu_operand` drives the ALU `input_data` directly, and its `alu_result` input is driven by the ALU `output_data`.

## Interface
- `NUM_LAYERS`, default 4: number of layers; the last layer has index `NUM_LAYERS-1`.
- `ELEM_W`, default 64: width of one packed element.
- `MAX_ELEMS`, default 6: number of element slots on the operand and result buses.
- `FRAC_SHIFT`, default 8: arithmetic right shift applied to hidden-layer outputs (weights are Q.8).
- `SETTLE_CYCLES`, default 1: cycles the block waits after changing `layer_number` so the weight register can reload (range 1..15).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input vector valid.
- `in_ready` out 1: block can accept an input vector.
- `in_data` in 3*ELEM_W: three signed inputs; element 0 at [191:128], element 2 at [63:0].
- `layer_number` out 2: drives the weights ROM select.
- `cols` in 4: neuron count of the current layer, from the weight register.
- `alu_enable` out 1: one-cycle ALU compute strobe.
- `alu_operand` out MAX_ELEMS*ELEM_W: packed operand; element i at bits [ELEM_W*(rows-i)-1 : ELEM_W*(rows-1-i)]; unused upper slots are 0.
- `alu_result` in MAX_ELEMS*ELEM_W: ALU output; element j at [ELEM_W*(cols-j)-1 : ELEM_W*(cols-1-j)].
- `out_valid` out 1: final result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out ELEM_W: signed raw output of the last layer.
- `out_class` out 1: 1 when `out_data > 0`.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, SETTLE, COMPUTE, CAPTURE, DONE.
- **IDLE:** `in_ready`=1. When `in_valid` is high, the block on that edge:
  - loads `alu_operand` with `{192'd0, in_data}`;
  - sets `layer_number` to 0;
  - loads the settle counter with `SETTLE_CYCLES-1`;
  - moves to SETTLE.
- **SETTLE:** counts down the settle counter; when it reaches 0, moves to COMPUTE. `alu_operand` and `layer_number` are held.
- **COMPUTE:** `alu_enable`=1 for exactly this cycle, then moves to CAPTURE.
- **CAPTURE (hidden layer, `layer_number` < NUM_LAYERS-1):**
  - for each j < `cols`, operand element j = 0 if `alu_result` element j is negative, otherwise (element j >>> FRAC_SHIFT);
  - slots j >= `cols` are zeroed;
  - `layer_number` increments, the settle counter reloads, and the block moves to SETTLE.
  - The repacking uses the current `cols`, so the next layer's rows equals this layer's cols.
- **CAPTURE (last layer):** `out_data` is set to element 0 of `alu_result` (bits [63:0], since `cols`=1) with no ReLU and no shift. `out_class` is updated, `out_valid` is set to 1, and the block moves to DONE.
- **DONE:** `out_data` and `out_class` are held stable. When `out_ready` is high, `out_valid` drops to 0 and the block returns to IDLE.
- **Ignored events:**
  - `in_valid` outside IDLE has no effect (`in_ready`=0);
  - `out_ready` while `out_valid`=0 has no effect.
- **Arithmetic:** signed two's complement. The shift is arithmetic, but it only ever sees non-negative values after ReLU, so no saturation is needed.

## Timing
- **Reset values:** `rst_n` low forces the following immediately, regardless of state or clock:
  - state IDLE, `layer_number`=0, `alu_operand`=0, `alu_enable`=0;
  - `out_valid`=0, `out_data`=0, `out_class`=0, `busy`=0;
  - `in_ready`=1 (decoded from IDLE).
- **Reset mid-inference:** abandons the inference; no `out_valid` is produced for it.
- `in_ready`, `busy` and `alu_enable` are decoded from state. All other outputs are registered.
- **Per-layer cycles:** SETTLE_CYCLES + 2. `layer_number` changes on the edge entering SETTLE; the weight register is valid from the next edge; the ALU registers its result on the edge that ends COMPUTE; CAPTURE samples it.
- **Latency:** from the accept edge to the first cycle with `out_valid` high is 4*(SETTLE_CYCLES+2)+1, which is 13 cycles at the default.
- **No bypass:** DONE to IDLE takes one cycle, and `in_ready` is never high in the same cycle as `out_valid`. Minimum initiation interval is 14 cycles at the default.

## Test plan
1. **Reset:** hold `rst_n` low mid-COMPUTE of layer 2 → all outputs reach their reset values asynchronously; after release `in_ready`=1 and `layer_number`=0.
2. **Zero input:** with production weights, accept `in_data`=0 → `layer_number` sequence 0,1,2,3; `out_valid` rises 13 cycles after accept; `out_data`=-82 (0xFFFF_FFFF_FFFF_FFAE); `out_class`=0.
3. **ReLU/rescale:** stub ALU returns layer-0 elements {-5, 256, 1000} with `cols`=3 → `alu_operand` for layer 1 = {0, 1, 3} at [191:0], upper 192 bits 0.
4. **Output backpressure:** keep `out_ready`=0 for 20 cycles after `out_valid` → `out_data` stable, `in_ready`=0. Raise `out_ready` for one cycle → `out_valid`=0 and `in_ready`=1 on the next cycle.
5. **Input while busy:** pulse `in_valid` with new data during layer 1 → ignored; the result matches the first vector; the second vector is accepted only once back in IDLE.
6. **Long settle:** with `SETTLE_CYCLES`=3 → `alu_enable` fires 3 cycles after each `layer_number` change; latency is 21 cycles.
